// File: rtl/lut_bit_reader_pkg.sv
// lut_bit_pkg: shared types and widths for the LUT-driven bit-field reader.
//   lbr_state_t : sequencer states (IDLE, LOOKUP, RD, MRG, DONE)
//   BIT_ADDR_W  : bit address width returned by the key lookup table
//   BYTE_ADDR_W : byte address width toward data memory
//   KEY_W       : symbolic field key width
//   LEN_W       : field length width (can express illegal lengths above MAX_LEN)
//   CUR_W       : cursor width, one bit wider than a bit address so the
//                 end-of-field check and post-increment never wrap
package lut_bit_pkg;

  localparam int BIT_ADDR_W  = 8;
  localparam int BYTE_ADDR_W = 5;
  localparam int KEY_W       = 4;
  localparam int LEN_W       = 5;
  localparam int CUR_W       = BIT_ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_RD     = 3'd2,
    ST_MRG    = 3'd3,
    ST_DONE   = 3'd4
  } lbr_state_t;

endpackage

// File: rtl/lut_bit_reader_if.sv
// lut_bit_reader_if: request/response, lookup-table and data-memory signals
// of the bit-field reader.
//   master : environment side (requester, lookup table, memory, consumer)
//   slave  : the reader itself
// Parameter MAX_LEN sets the response data width.
interface lut_bit_reader_if #(
  parameter int MAX_LEN = 16
) ();

  logic                               req_valid;
  logic [lut_bit_pkg::KEY_W-1:0]      req_key;
  logic [lut_bit_pkg::LEN_W-1:0]      req_len;
  logic                               req_ready;
  logic [lut_bit_pkg::KEY_W-1:0]      lut_key;
  logic [lut_bit_pkg::BIT_ADDR_W-1:0] lut_addr;
  logic                               mem_rd;
  logic [lut_bit_pkg::BYTE_ADDR_W-1:0] mem_addr;
  logic [7:0]                         mem_rdata;
  logic                               rsp_valid;
  logic [MAX_LEN-1:0]                 rsp_data;
  logic                               rsp_err;
  logic                               rsp_ready;

  modport master (
    output req_valid, req_key, req_len, lut_addr, mem_rdata, rsp_ready,
    input  req_ready, lut_key, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_key, req_len, lut_addr, mem_rdata, rsp_ready,
    output req_ready, lut_key, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/lut_bit_reader_bit_extract.sv
// bit_extract: combinational slice of an MSB-first byte.
//   byte_i   : source byte, bit address order runs MSB to LSB
//   offset_i : first bit taken, counted from the MSB (position 7-offset)
//   count_i  : number of bits taken, 0..8 (offset + count never exceeds 8)
//   bits_o   : extracted bits, right-aligned, upper bits zero
module bit_extract (
  input  logic [7:0] byte_i,
  input  logic [2:0] offset_i,
  input  logic [3:0] count_i,
  output logic [7:0] bits_o
);

  logic [7:0] aligned;

  // Left shift drops the bits ahead of the cursor; the right shift then keeps
  // the top count_i bits. A count of zero shifts everything out.
  assign aligned = byte_i << offset_i;
  assign bits_o  = aligned >> (4'd8 - count_i);

endmodule

// File: rtl/lut_bit_reader.sv
// lut_bit_reader: turns a field key into an MSB-first bit-field read from
// byte-wide memory, using an external key-to-bit-address lookup table.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of lut_bit_reader_if (request, lookup, memory, response)
// MAX_LEN must be at least 8 (one full byte merges in a single step).
//
// state  | meaning
// IDLE   | ready for a request, latches key and length
// LOOKUP | lookup table answers; load cursor/remaining, range-check request
// RD     | issue byte read at cursor[7:3]
// MRG    | merge returned bits into the accumulator, advance cursor
// DONE   | hold response until rsp_ready
module lut_bit_reader
  import lut_bit_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lut_bit_reader_if.slave  bus
);

  lbr_state_t         state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [CUR_W-1:0]   cur_q, cur_d;
  logic [MAX_LEN-1:0] acc_q, acc_d;
  logic               err_q, err_d;

  logic [3:0]         avail;
  logic [3:0]         take;
  logic [7:0]         bits;
  logic [CUR_W:0]     end_addr;
  logic               bad_req;

  // Bits left in the current byte from the cursor onward (1..8).
  assign avail = 4'd8 - {1'b0, cur_q[2:0]};
  assign take  = (rem_q < {1'b0, avail}) ? rem_q[3:0] : avail;

  bit_extract u_extract (
    .byte_i   (bus.mem_rdata),
    .offset_i (cur_q[2:0]),
    .count_i  (take),
    .bits_o   (bits)
  );

  // One past the last bit; anything beyond 256 runs off the end of memory.
  assign end_addr = {2'b00, bus.lut_addr} + {{(CUR_W+1-LEN_W){1'b0}}, len_q};
  assign bad_req  = (len_q == '0) || (int'(len_q) > MAX_LEN) ||
                    (end_addr > (CUR_W+1)'(256));

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    len_d   = len_q;
    rem_d   = rem_q;
    cur_d   = cur_q;
    acc_d   = acc_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          key_d   = bus.req_key;
          len_d   = bus.req_len;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        cur_d = {1'b0, bus.lut_addr};
        rem_d = len_q;
        acc_d = '0;
        if (bad_req) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        state_d = ST_MRG;
      end
      ST_MRG: begin
        acc_d   = (acc_q << take) | MAX_LEN'(bits);
        cur_d   = cur_q + CUR_W'(take);
        rem_d   = rem_q - LEN_W'(take);
        state_d = (rem_q == LEN_W'(take)) ? ST_DONE : ST_RD;
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      cur_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      cur_q   <= cur_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // Outputs are pure decodes of registers so reset reaches them immediately.
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.lut_key   = key_q;
  assign bus.mem_rd    = (state_q == ST_RD);
  assign bus.mem_addr  = cur_q[7:3];
  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.rsp_data  = acc_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: doc/lut_bit_reader.md
# lut_bit_reader

Sequencer that turns a symbolic field key into an MSB-first bit-field read from byte-wide data memory. It drives the 4-bit key into the team's key-to-bit-address lookup table and converts the returned 8-bit bit address into byte reads. It then merges up to 16 consecutive bits into a right-aligned word. It sits between the parity/codeword datapath and data memory, replacing per-bit address arithmetic in software.

## Interface
- `MAX_LEN`, 16: maximum field length in bits. Sets the `rsp_data` width.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request strobe.
- `req_key`  in  4  lookup key.
- `req_len`  in  5  field length; legal range 1..MAX_LEN.
- `req_ready`  out  1  high only in IDLE.
- `lut_key`  out  4  key to the lookup table; registered copy of `req_key`.
- `lut_addr`  in  8  combinational bit address from the lookup table.
- `mem_rd`  out  1  byte read strobe.
- `mem_addr`  out  5  byte address, equal to bit address [7:3].
- `mem_rdata`  in  8  read data, valid one cycle after `mem_rd`.
- `rsp_valid`  out  1  result available.
- `rsp_data`  out  MAX_LEN  field, right-aligned, upper bits zero.
- `rsp_err`  out  1  request rejected; `rsp_data` = 0.
- `rsp_ready`  in  1  consumer accepts the response.

## Operation
- Bit numbering: bit address b selects byte b[7:3], bit position 7−b[2:0]. Within a byte, address order runs from MSB to LSB.
- The first bit fetched becomes the MSB of the field.
- FSM states: IDLE, LOOKUP, RD, MRG, DONE.
- IDLE: a request is accepted when `req_valid` && `req_ready`. Key and length are latched; next state LOOKUP.
- LOOKUP: register cursor = `lut_addr` and remaining = `req_len`.
  - If len == 0, len > MAX_LEN, or `lut_addr` + len − 1 > 255: set `rsp_err`, go to DONE, issue no reads.
  - Otherwise go to RD.
- RD: assert `mem_rd` with `mem_addr` = cursor[7:3]; next state MRG.
- MRG: take n = min(remaining, 8 − cursor[2:0]) bits from `mem_rdata`, starting at position 7−cursor[2:0].
  - acc = (acc << n) | bits.
  - cursor += n; remaining −= n.
  - If remaining == 0, go to DONE; otherwise go to RD.
- DONE: `rsp_valid` = 1, holding `rsp_data`/`rsp_err` stable until `rsp_ready`. Then clear acc and return to IDLE.
- Arithmetic: cursor is 9 bits internally so the overflow check cannot wrap. remaining is 5 bits; acc is MAX_LEN bits.
- `req_valid` outside IDLE is ignored; there is no queueing.

## Timing
- Reset values: `req_ready` = 1 (IDLE), `mem_rd` = 0, `mem_addr` = 0, `lut_key` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0. State is IDLE.
- Accept at cycle T: LOOKUP at T+1; first `mem_rd` at T+2.
- Each touched byte costs 2 cycles. `rsp_valid` rises at T+2+2·bytes.
- Error path: `rsp_valid` at T+2.
- Fields spanning 1, 2, 3 bytes respond at T+4, T+6, T+8.
- `rsp_ready` held low stalls in DONE indefinitely with outputs frozen.
- `rsp_ready` high on the first DONE cycle gives a one-cycle response. `req_ready` returns the following cycle, so back-to-back requests are spaced by at least one IDLE cycle.
- `rst_n` low at any point, including mid-read, immediately forces all outputs to their reset values. A `mem_rdata` return after reset is ignored.

## Structure
- Shared package `lut_bit_pkg`:
  - state enum `lbr_state_t`;
  - `BIT_ADDR_W` = 8, `BYTE_ADDR_W` = 5, `KEY_W` = 4.
- The lookup table stays a separate existing block instantiated by the parent.
- Natural sub-module: `bit_extract`, combinational. Inputs are byte, offset and count; output is the extracted bits, right-aligned.

## Test plan
- mem[0] = 0xA5, key 0 (bit address 0), len 8 → one read of byte 0; `rsp_data` = 0x00A5 at T+4; `rsp_err` = 0.
- mem[0] = 0xA5, mem[1] = 0x3C, key 2 (bit address 5), len 5 → reads bytes 0 then 1; `rsp_data` = 0x0014 at T+6.
- mem[0..2] = 0xA5, 0x3C, 0xFF, key 1 (bit address 1), len 16 → three reads; `rsp_data` = 0x4A79 at T+8.
- Key 10 (bit address 255), len 2 → no `mem_rd`; `rsp_err` = 1, `rsp_data` = 0 at T+2. Key 9 (bit address 254), len 2 → legal single-byte read.
- len 0 and len 17 → `rsp_err` = 1. `rsp_ready` held low 5 cycles → `rsp_valid` and data stable, `req_ready` = 0, a new `req_valid` is ignored.
- Assert `rst_n` low during MRG of a 3-byte read → all outputs return to reset values the same cycle. A following request completes correctly.
